// File: rtl/hd44780_cmd_sequencer_pkg.sv
// Shared types and constants for the HD44780 command sequencer and its init ROM.
// H4_SEQ_AUTOINIT_EN (defined elsewhere) enables the built-in power-on init sequence.
`ifndef H4_TIMER_BITS
`define H4_TIMER_BITS 24
`endif
`ifndef H4_DELAY_100MS
`define H4_DELAY_100MS 5000000
`endif
`ifndef H4_DELAY_4P1MS
`define H4_DELAY_4P1MS 205000
`endif
`ifndef H4_DELAY_100US
`define H4_DELAY_100US 5000
`endif
`ifndef H4_DELAY_3MS
`define H4_DELAY_3MS 150000
`endif
`ifndef H4_DELAY_53US
`define H4_DELAY_53US 2650
`endif

package hd44780_cmd_sequencer_pkg;

  typedef enum logic [3:0] {
    H4SQ_ST_IDLE,
    H4SQ_ST_HI,
    H4SQ_ST_HI_WAIT,
    H4SQ_ST_LO,
    H4SQ_ST_LO_WAIT,
    H4SQ_ST_DLY,
    H4SQ_ST_DLY_WAIT,
    H4SQ_ST_PWRWAIT,
    H4SQ_ST_PWR_TWAIT,
    H4SQ_ST_INIT_NEXT,
    H4SQ_ST_INIT_NYB,
    H4SQ_ST_INIT_NWAIT
  } state_t;

  typedef enum logic [1:0] {
    DSEL_SHORT,
    DSEL_LONG,
    DSEL_4P1MS,
    DSEL_100US
  } delay_sel_t;

  typedef struct packed {
    logic       nybble_only;
    logic [7:0] byte_val;
    delay_sel_t delay_sel;
  } init_entry_t;

  localparam int         INIT_LEN       = 8;
  localparam logic [2:0] INIT_LAST_STEP = 3'(INIT_LEN - 1);

  localparam logic [7:0] H4_CMD_CLEAR        = 8'h01;
  localparam logic [7:0] H4_CMD_HOME         = 8'h02;
  localparam logic [7:0] H4_CMD_HOME_ALT     = 8'h03;
  localparam logic [7:0] H4_CMD_ENTRY_INC    = 8'h06;
  localparam logic [7:0] H4_CMD_DISPLAY_ON   = 8'h0C;
  localparam logic [7:0] H4_CMD_FUNCSET_4B2L = 8'h28;
  localparam logic [7:0] H4_WAKE_NYB         = 8'h03;
  localparam logic [7:0] H4_SET_4BIT_NYB     = 8'h02;

  // Clear and home are the only instructions that need the long execution time.
  function automatic delay_sel_t byte_delay_sel(input logic rs, input logic [7:0] data);
    if (!rs && (data inside {H4_CMD_CLEAR, H4_CMD_HOME, H4_CMD_HOME_ALT}))
      return DSEL_LONG;
    return DSEL_SHORT;
  endfunction

endpackage

// File: rtl/hd44780_cmd_sequencer_init_rom.sv
// Power-on init table for the HD44780 sequencer: step -> {nybble_only, byte, delay_sel}.
// Only built when H4_SEQ_AUTOINIT_EN is defined.
`ifdef H4_SEQ_AUTOINIT_EN
module hd44780_cmd_sequencer_init_rom
  import hd44780_cmd_sequencer_pkg::*;
(
  input  logic [2:0]  step,
  output init_entry_t entry
);

  always_comb begin
    entry = '{nybble_only: 1'b0, byte_val: 8'h00, delay_sel: DSEL_SHORT};
    case (step)
      3'd0: entry = '{nybble_only: 1'b1, byte_val: H4_WAKE_NYB,         delay_sel: DSEL_4P1MS};
      3'd1: entry = '{nybble_only: 1'b1, byte_val: H4_WAKE_NYB,         delay_sel: DSEL_100US};
      3'd2: entry = '{nybble_only: 1'b1, byte_val: H4_WAKE_NYB,         delay_sel: DSEL_100US};
      3'd3: entry = '{nybble_only: 1'b1, byte_val: H4_SET_4BIT_NYB,     delay_sel: DSEL_100US};
      3'd4: entry = '{nybble_only: 1'b0, byte_val: H4_CMD_FUNCSET_4B2L, delay_sel: DSEL_SHORT};
      3'd5: entry = '{nybble_only: 1'b0, byte_val: H4_CMD_DISPLAY_ON,   delay_sel: DSEL_SHORT};
      3'd6: entry = '{nybble_only: 1'b0, byte_val: H4_CMD_CLEAR,        delay_sel: DSEL_LONG};
      3'd7: entry = '{nybble_only: 1'b0, byte_val: H4_CMD_ENTRY_INC,    delay_sel: DSEL_SHORT};
    endcase
  end

endmodule
`endif

// File: rtl/hd44780_cmd_sequencer.sv
// HD44780 4-bit command sequencer: splits {rs,byte} commands into nybbles and loads post-command delays.
// Defining H4_SEQ_AUTOINIT_EN makes it run the LCD power-on init sequence after every reset.
module hd44780_cmd_sequencer
  import hd44780_cmd_sequencer_pkg::*;
#(
  parameter int          TIMER_BITS = `H4_TIMER_BITS,
  parameter int unsigned DLY_PWRUP  = `H4_DELAY_100MS,
  parameter int unsigned DLY_4P1MS  = `H4_DELAY_4P1MS,
  parameter int unsigned DLY_100US  = `H4_DELAY_100US,
  parameter int unsigned DLY_LONG   = `H4_DELAY_3MS,
  parameter int unsigned DLY_SHORT  = `H4_DELAY_53US
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rs,
  input  logic [7:0]            cmd_data,
  output logic                  nyb_stb,
  output logic                  nyb_rs,
  output logic [3:0]            nyb_data,
  input  logic                  nyb_done,
  output logic [TIMER_BITS-1:0] tmr_dat,
  output logic                  tmr_start,
  input  logic                  tmr_end,
  output logic                  init_done,
  output logic                  busy
);

`ifdef H4_SEQ_AUTOINIT_EN
  localparam state_t RESET_STATE = H4SQ_ST_PWRWAIT;
  localparam logic   RESET_BUSY  = 1'b1;

  logic [2:0]  step;
  init_entry_t rom_entry;

  hd44780_cmd_sequencer_init_rom u_init_rom (
    .step  (step),
    .entry (rom_entry)
  );
`else
  localparam state_t RESET_STATE = H4SQ_ST_IDLE;
  localparam logic   RESET_BUSY  = 1'b0;
`endif

  state_t     state;
  logic       latch_rs;
  logic [7:0] latch_data;

  // Delay values are cast so an oversized parameter truncates and a small one zero-extends.
  function automatic logic [TIMER_BITS-1:0] delay_ticks(input logic pwrup, input delay_sel_t sel);
    if (pwrup)
      return TIMER_BITS'(DLY_PWRUP);
    case (sel)
      DSEL_LONG:  return TIMER_BITS'(DLY_LONG);
      DSEL_4P1MS: return TIMER_BITS'(DLY_4P1MS);
      DSEL_100US: return TIMER_BITS'(DLY_100US);
      default:    return TIMER_BITS'(DLY_SHORT);
    endcase
  endfunction

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state      <= RESET_STATE;
      cmd_ready  <= 1'b0;
      nyb_stb    <= 1'b0;
      nyb_rs     <= 1'b0;
      nyb_data   <= 4'h0;
      tmr_dat    <= '0;
      tmr_start  <= 1'b0;
      init_done  <= 1'b0;
      busy       <= RESET_BUSY;
      latch_rs   <= 1'b0;
      latch_data <= 8'h00;
`ifdef H4_SEQ_AUTOINIT_EN
      step       <= 3'd0;
`endif
    end else begin
      nyb_stb   <= 1'b0;
      tmr_start <= 1'b0;
      case (state)
        H4SQ_ST_IDLE: begin
          init_done <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            latch_rs   <= cmd_rs;
            latch_data <= cmd_data;
            nyb_stb    <= 1'b1;
            nyb_rs     <= cmd_rs;
            nyb_data   <= cmd_data[7:4];
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            state      <= H4SQ_ST_HI;
          end else begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        H4SQ_ST_HI: state <= H4SQ_ST_HI_WAIT;
        H4SQ_ST_HI_WAIT: begin
          if (nyb_done) begin
            nyb_stb  <= 1'b1;
            nyb_data <= latch_data[3:0];
            state    <= H4SQ_ST_LO;
          end
        end
        H4SQ_ST_LO: state <= H4SQ_ST_LO_WAIT;
        H4SQ_ST_LO_WAIT: begin
          if (nyb_done) begin
            tmr_start <= 1'b1;
            tmr_dat   <= delay_ticks(1'b0, byte_delay_sel(latch_rs, latch_data));
            state     <= H4SQ_ST_DLY;
          end
        end
        H4SQ_ST_DLY: state <= H4SQ_ST_DLY_WAIT;
        // Delay expiry either finishes a command or advances the init table.
        H4SQ_ST_DLY_WAIT: begin
          if (tmr_end) begin
`ifdef H4_SEQ_AUTOINIT_EN
            if (!init_done && step != INIT_LAST_STEP) begin
              step  <= step + 3'd1;
              state <= H4SQ_ST_INIT_NEXT;
            end else begin
              init_done <= 1'b1;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
              state     <= H4SQ_ST_IDLE;
            end
`else
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= H4SQ_ST_IDLE;
`endif
          end
        end
`ifdef H4_SEQ_AUTOINIT_EN
        H4SQ_ST_PWRWAIT: begin
          tmr_start <= 1'b1;
          tmr_dat   <= delay_ticks(1'b1, DSEL_SHORT);
          state     <= H4SQ_ST_PWR_TWAIT;
        end
        H4SQ_ST_PWR_TWAIT: if (tmr_end) state <= H4SQ_ST_INIT_NEXT;
        // Wake-up steps send a lone nybble; later steps reuse the byte path with rs=0.
        H4SQ_ST_INIT_NEXT: begin
          nyb_stb <= 1'b1;
          nyb_rs  <= 1'b0;
          if (rom_entry.nybble_only) begin
            nyb_data <= rom_entry.byte_val[3:0];
            state    <= H4SQ_ST_INIT_NYB;
          end else begin
            latch_rs   <= 1'b0;
            latch_data <= rom_entry.byte_val;
            nyb_data   <= rom_entry.byte_val[7:4];
            state      <= H4SQ_ST_HI;
          end
        end
        H4SQ_ST_INIT_NYB: state <= H4SQ_ST_INIT_NWAIT;
        H4SQ_ST_INIT_NWAIT: begin
          if (nyb_done) begin
            tmr_start <= 1'b1;
            tmr_dat   <= delay_ticks(1'b0, rom_entry.delay_sel);
            state     <= H4SQ_ST_DLY;
          end
        end
`endif
        default: state <= H4SQ_ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hd44780_cmd_sequencer.sv
// Directed bench for hd44780_cmd_sequencer with a behavioural nybble sender and timer responder.
// Covers both builds; the init-sequence scenarios run only when H4_SEQ_AUTOINIT_EN is defined.
module tb_hd44780_cmd_sequencer;

  localparam logic [15:0] EXP_PWRUP = 16'h1170;
  localparam logic [15:0] EXP_4P1MS = 16'd410;
  localparam logic [15:0] EXP_100US = 16'd10;
  localparam logic [15:0] EXP_LONG  = 16'd300;
  localparam logic [15:0] EXP_SHORT = 16'd5;
  localparam int          NYB_LAT   = 2;
  localparam int          TMR_LAT   = 5;
  localparam int          CMD_CYCLES = 12;
`ifdef H4_SEQ_AUTOINIT_EN
  localparam logic EXP_RESET_BUSY = 1'b1;
`else
  localparam logic EXP_RESET_BUSY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_rs;
  logic [7:0]  cmd_data;
  logic        nyb_stb, nyb_rs, nyb_done;
  logic [3:0]  nyb_data;
  logic [15:0] tmr_dat;
  logic        tmr_start, tmr_end;
  logic        init_done, busy;

  int checks = 0;
  int errors = 0;

  logic [4:0]  nyb_log[$];
  logic [15:0] tmr_log[$];
  int nyb_cnt = 0;
  int tmr_cnt = 0;
  int inj_nyb_req = 0, inj_nyb_ack = 0;
  int inj_tmr_req = 0, inj_tmr_ack = 0;

  hd44780_cmd_sequencer #(
    .TIMER_BITS (16),
    .DLY_PWRUP  (70000),
    .DLY_4P1MS  (410),
    .DLY_100US  (10),
    .DLY_LONG   (300),
    .DLY_SHORT  (5)
  ) dut (
    .CLK_I     (clk),
    .RST_I     (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rs    (cmd_rs),
    .cmd_data  (cmd_data),
    .nyb_stb   (nyb_stb),
    .nyb_rs    (nyb_rs),
    .nyb_data  (nyb_data),
    .nyb_done  (nyb_done),
    .tmr_dat   (tmr_dat),
    .tmr_start (tmr_start),
    .tmr_end   (tmr_end),
    .init_done (init_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Responder: logs every strobe/start, answers after fixed latencies, injects spurious pulses on request.
  always begin
    @(posedge clk);
    #2;
    nyb_done = 1'b0;
    tmr_end  = 1'b0;
    if (rst) begin
      nyb_cnt = 0;
      tmr_cnt = 0;
    end else begin
      if (nyb_cnt > 0) begin
        nyb_cnt--;
        if (nyb_cnt == 0) nyb_done = 1'b1;
      end
      if (tmr_cnt > 0) begin
        tmr_cnt--;
        if (tmr_cnt == 0) tmr_end = 1'b1;
      end
      if (nyb_stb) begin
        nyb_log.push_back({nyb_rs, nyb_data});
        nyb_cnt = NYB_LAT;
      end
      if (tmr_start) begin
        tmr_log.push_back(tmr_dat);
        tmr_cnt = TMR_LAT;
      end
      if (inj_nyb_req != inj_nyb_ack) begin
        inj_nyb_ack = inj_nyb_req;
        nyb_done = 1'b1;
      end
      if (inj_tmr_req != inj_tmr_ack) begin
        inj_tmr_ack = inj_tmr_req;
        tmr_end = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one command, releases valid after acceptance and waits (bounded) for ready.
  task automatic run_cmd(input logic rs, input logic [7:0] data, output int cycles);
    cmd_valid = 1'b1;
    cmd_rs    = rs;
    cmd_data  = data;
    tick();
    cmd_valid = 1'b0;
    cycles = 0;
    while (cmd_ready !== 1'b1 && cycles < 200) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({cmd_ready, nyb_stb, nyb_rs, nyb_data, tmr_start, init_done} !== 9'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %b expected 0", {cmd_ready, nyb_stb, nyb_rs, nyb_data, tmr_start, init_done});
    end
    checks++;
    if (tmr_dat !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_tmr_dat got %h expected 0", tmr_dat);
    end
    checks++;
    if (busy !== EXP_RESET_BUSY) begin
      errors++;
      $display("[TB] FAIL reset_busy got %b expected %b", busy, EXP_RESET_BUSY);
    end
    rst = 1'b0;
  endtask

  task automatic wait_init();
    int cycles = 0;
    while (init_done !== 1'b1 && cycles < 3000) begin
      tick();
      cycles++;
    end
    checks++;
    if (init_done !== 1'b1 || cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL init_complete got done=%b ready=%b expected 1 1", init_done, cmd_ready);
    end
  endtask

`ifdef H4_SEQ_AUTOINIT_EN
  task automatic test_init_sequence();
    logic [3:0]  exp_nyb [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'hC, 4'h0, 4'h1, 4'h0, 4'h6};
    logic [15:0] exp_tmr [9]  = '{EXP_PWRUP, EXP_4P1MS, EXP_100US, EXP_100US, EXP_100US,
                                  EXP_SHORT, EXP_SHORT, EXP_LONG, EXP_SHORT};
    int nb = nyb_log.size();
    int tb = tmr_log.size();
    int early_ready = 0;
    tick();
    checks++;
    if (tmr_start !== 1'b1 || tmr_dat !== EXP_PWRUP) begin
      errors++;
      $display("[TB] FAIL pwrup_start got start=%b dat=%h expected 1 %h", tmr_start, tmr_dat, EXP_PWRUP);
    end
    for (int i = 0; i < 3000 && init_done !== 1'b1; i++) begin
      if (cmd_ready === 1'b1) early_ready++;
      tick();
    end
    checks++;
    if (early_ready != 0) begin
      errors++;
      $display("[TB] FAIL ready_during_init got %0d cycles high expected 0", early_ready);
    end
    wait_init();
    checks++;
    if (nyb_log.size() - nb != 12) begin
      errors++;
      $display("[TB] FAIL init_nyb_count got %0d expected 12", nyb_log.size() - nb);
    end
    for (int i = 0; i < 12 && nb + i < nyb_log.size(); i++) begin
      checks++;
      if (nyb_log[nb + i] !== {1'b0, exp_nyb[i]}) begin
        errors++;
        $display("[TB] FAIL init_nyb_%0d got %h expected %h", i, nyb_log[nb + i], {1'b0, exp_nyb[i]});
      end
    end
    checks++;
    if (tmr_log.size() - tb != 9) begin
      errors++;
      $display("[TB] FAIL init_tmr_count got %0d expected 9", tmr_log.size() - tb);
    end
    for (int i = 0; i < 9 && tb + i < tmr_log.size(); i++) begin
      checks++;
      if (tmr_log[tb + i] !== exp_tmr[i]) begin
        errors++;
        $display("[TB] FAIL init_tmr_%0d got %h expected %h", i, tmr_log[tb + i], exp_tmr[i]);
      end
    end
  endtask
`else
  task automatic test_no_autoinit();
    tick();
    checks++;
    if ({cmd_ready, init_done, busy, nyb_stb, tmr_start} !== 5'b11000) begin
      errors++;
      $display("[TB] FAIL first_clock got %b expected 11000", {cmd_ready, init_done, busy, nyb_stb, tmr_start});
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (nyb_log.size() != 0 || tmr_log.size() != 0) begin
      errors++;
      $display("[TB] FAIL idle_quiet got nyb=%0d tmr=%0d expected 0 0", nyb_log.size(), tmr_log.size());
    end
  endtask
`endif

  task automatic test_single_command();
    int nb = nyb_log.size();
    int tb = tmr_log.size();
    int cycles = 0;
    cmd_valid = 1'b1;
    cmd_rs    = 1'b1;
    cmd_data  = 8'h41;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if ({cmd_ready, busy, nyb_stb, nyb_rs, nyb_data} !== 8'b0111_0100) begin
      errors++;
      $display("[TB] FAIL accept_cycle got %b expected 01110100", {cmd_ready, busy, nyb_stb, nyb_rs, nyb_data});
    end
    while (cmd_ready !== 1'b1 && cycles < 200) begin
      tick();
      cycles++;
    end
    checks++;
    if (cycles != CMD_CYCLES || tmr_end !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_return got cycles=%0d tmr_end=%b expected %0d 1", cycles, tmr_end, CMD_CYCLES);
    end
    checks++;
    if (nyb_log.size() - nb != 2 || nyb_log[nb] !== 5'h14 || nyb_log[nb + 1] !== 5'h11) begin
      errors++;
      $display("[TB] FAIL cmd_nybbles got n=%0d %h %h expected 2 14 11", nyb_log.size() - nb, nyb_log[nb], nyb_log[nb + 1]);
    end
    checks++;
    if (tmr_log.size() - tb != 1 || tmr_log[tb] !== EXP_SHORT) begin
      errors++;
      $display("[TB] FAIL cmd_delay got n=%0d %h expected 1 %h", tmr_log.size() - tb, tmr_log[tb], EXP_SHORT);
    end
  endtask

  task automatic test_delay_select();
    logic [8:0]  vec [5] = '{9'h001, 9'h101, 9'h003, 9'h004, 9'h000};
    logic [15:0] exp [5] = '{EXP_LONG, EXP_SHORT, EXP_LONG, EXP_SHORT, EXP_SHORT};
    int tb, cycles;
    for (int i = 0; i < 5; i++) begin
      tb = tmr_log.size();
      run_cmd(vec[i][8], vec[i][7:0], cycles);
      checks++;
      if (cycles != CMD_CYCLES || tmr_log.size() - tb != 1 || tmr_log[tb] !== exp[i]) begin
        errors++;
        $display("[TB] FAIL delay_sel_%h got cycles=%0d dat=%h expected %0d %h", vec[i], cycles, tmr_log[tb], CMD_CYCLES, exp[i]);
      end
    end
  endtask

  task automatic test_spurious();
    int nb = nyb_log.size();
    int tb = tmr_log.size();
    int cycles = 1;
    cmd_valid = 1'b1;
    cmd_rs    = 1'b1;
    cmd_data  = 8'h5C;
    tick();
    cmd_valid = 1'b0;
    tick();
    inj_tmr_req++;
    while (cmd_ready !== 1'b1 && cycles < 200) begin
      tick();
      cycles++;
      if (cycles == 7) inj_nyb_req++;
    end
    checks++;
    if (cycles != CMD_CYCLES) begin
      errors++;
      $display("[TB] FAIL spurious_cycles got %0d expected %0d", cycles, CMD_CYCLES);
    end
    checks++;
    if (nyb_log.size() - nb != 2 || nyb_log[nb] !== 5'h15 || nyb_log[nb + 1] !== 5'h1C) begin
      errors++;
      $display("[TB] FAIL spurious_nybbles got n=%0d %h %h expected 2 15 1c", nyb_log.size() - nb, nyb_log[nb], nyb_log[nb + 1]);
    end
    checks++;
    if (tmr_log.size() - tb != 1 || tmr_log[tb] !== EXP_SHORT) begin
      errors++;
      $display("[TB] FAIL spurious_delay got n=%0d %h expected 1 %h", tmr_log.size() - tb, tmr_log[tb], EXP_SHORT);
    end
  endtask

  task automatic test_reset_mid_command();
    int nb = nyb_log.size();
    int tb;
    cmd_valid = 1'b1;
    cmd_rs    = 1'b0;
    cmd_data  = 8'h28;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (nyb_log.size() - nb != 2 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lo_wait_reached got n=%0d busy=%b expected 2 1", nyb_log.size() - nb, busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({cmd_ready, nyb_stb, nyb_rs, nyb_data, tmr_start, init_done, busy} !== {9'b0, EXP_RESET_BUSY} || tmr_dat !== 16'h0) begin
      errors++;
      $display("[TB] FAIL async_reset got %b dat=%h expected %b 0", {cmd_ready, nyb_stb, nyb_rs, nyb_data, tmr_start, init_done, busy}, tmr_dat, {9'b0, EXP_RESET_BUSY});
    end
    tick();
    tick();
    rst = 1'b0;
    nb = nyb_log.size();
    tb = tmr_log.size();
    tick();
`ifdef H4_SEQ_AUTOINIT_EN
    checks++;
    if (tmr_start !== 1'b1 || tmr_dat !== EXP_PWRUP || cmd_ready !== 1'b0 || init_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL restart_pwrup got start=%b dat=%h ready=%b done=%b expected 1 %h 0 0", tmr_start, tmr_dat, cmd_ready, init_done, EXP_PWRUP);
    end
`else
    checks++;
    if (cmd_ready !== 1'b1 || init_done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL restart_idle got ready=%b done=%b busy=%b expected 1 1 0", cmd_ready, init_done, busy);
    end
`endif
    tick();
    tick();
    checks++;
    if (nyb_log.size() != nb || tmr_log.size() - tb > 1) begin
      errors++;
      $display("[TB] FAIL dropped_command got nyb=%0d tmr=%0d expected 0 <=1", nyb_log.size() - nb, tmr_log.size() - tb);
    end
    wait_init();
  endtask

  // Valid stays high throughout: the second command must wait until the first has fully finished.
  task automatic test_back_to_back();
    int nb = nyb_log.size();
    int tb = tmr_log.size();
    int cycles = 0;
    cmd_valid = 1'b1;
    cmd_rs    = 1'b0;
    cmd_data  = 8'h02;
    tick();
    cmd_rs   = 1'b1;
    cmd_data = 8'h9A;
    while (cmd_ready !== 1'b1 && cycles < 400) begin
      tick();
      cycles++;
    end
    checks++;
    if (nyb_log.size() - nb != 2 || cycles != CMD_CYCLES) begin
      errors++;
      $display("[TB] FAIL held_valid_ignored got n=%0d cycles=%0d expected 2 %0d", nyb_log.size() - nb, cycles, CMD_CYCLES);
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if ({cmd_ready, nyb_stb, nyb_rs, nyb_data} !== 7'b0_1_1_1001) begin
      errors++;
      $display("[TB] FAIL second_accept got %b expected 0111001", {cmd_ready, nyb_stb, nyb_rs, nyb_data});
    end
    cycles = 0;
    while (cmd_ready !== 1'b1 && cycles < 200) begin
      tick();
      cycles++;
    end
    checks++;
    if (nyb_log.size() - nb != 4 || nyb_log[nb] !== 5'h00 || nyb_log[nb + 1] !== 5'h02 ||
        nyb_log[nb + 2] !== 5'h19 || nyb_log[nb + 3] !== 5'h1A) begin
      errors++;
      $display("[TB] FAIL b2b_nybbles got n=%0d %h %h %h %h expected 4 00 02 19 1a", nyb_log.size() - nb,
               nyb_log[nb], nyb_log[nb + 1], nyb_log[nb + 2], nyb_log[nb + 3]);
    end
    checks++;
    if (tmr_log.size() - tb != 2 || tmr_log[tb] !== EXP_LONG || tmr_log[tb + 1] !== EXP_SHORT) begin
      errors++;
      $display("[TB] FAIL b2b_delays got n=%0d %h %h expected 2 %h %h", tmr_log.size() - tb, tmr_log[tb], tmr_log[tb + 1], EXP_LONG, EXP_SHORT);
    end
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_rs    = 1'b0;
    cmd_data  = 8'h00;
    nyb_done  = 1'b0;
    tmr_end   = 1'b0;
    test_reset();
`ifdef H4_SEQ_AUTOINIT_EN
    test_init_sequence();
`else
    test_no_autoinit();
`endif
    test_single_command();
    test_delay_select();
    test_spurious();
    test_reset_mid_command();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
